// File: rtl/crc32_frame_checker.sv
// ---------------------------------------------------------------------------
// crc32_frame_checker
//
// Receive-side CRC-32 frame checker. Accepts a byte stream over valid/ready.
// Each frame is payload bytes followed by a 4-byte big-endian CRC trailer.
// The payload CRC is recomputed with the same per-byte update as the
// generator and compared with the trailer. A one-cycle frame_done pulse
// reports the verdict and the payload length.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   in_valid        byte valid
//   in_ready        block can accept a byte (low only during CHECK)
//   in_data[7:0]    stream byte (sampled on accept only)
//   in_last         final byte of the frame (last trailer byte)
//   frame_done      one-cycle pulse, verdict outputs valid
//   frame_ok        CRC matched and frame is not a runt
//   frame_runt      frame shorter than MIN_PAYLOAD+4 bytes
//   frame_len       payload byte count (total minus 4, saturating)
//   good_count      good-frame counter (only with CRC32_CHK_STATS_EN)
//   bad_count       bad-frame counter  (only with CRC32_CHK_STATS_EN)
//
// Build option: define CRC32_CHK_STATS_EN to enable the saturating
// good/bad frame counters; otherwise both outputs are tied to zero.
// ---------------------------------------------------------------------------
module crc32_frame_checker #(
   parameter logic [31:0] POLY        = 32'h04C11DB7,
   parameter logic [31:0] INIT        = 32'hFFFFFFFF,
   parameter int unsigned MIN_PAYLOAD = 1,
   parameter int unsigned LEN_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             frame_done,
   output logic             frame_ok,
   output logic             frame_runt,
   output logic [LEN_W-1:0] frame_len,
   output logic [15:0]      good_count,
   output logic [15:0]      bad_count
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK} state_t;

   localparam logic [LEN_W:0] CNT_ONE  = (LEN_W+1)'(1);
   localparam logic [LEN_W:0] CNT_FOUR = (LEN_W+1)'(4);
   localparam logic [LEN_W:0] CNT_MAX  = {(LEN_W+1){1'b1}};
   localparam logic [LEN_W:0] RUNT_LIM = (LEN_W+1)'(MIN_PAYLOAD + 4);
   localparam logic [LEN_W:0] LEN_MAX  = {1'b0, {LEN_W{1'b1}}};

   // Per-byte CRC update, data bit 0 first, shift-left form.
   function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                            input logic [7:0]  d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ d[i]) r = (r << 1) ^ POLY;
         else              r = r << 1;
      end
      return r;
   endfunction

   state_t           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [31:0]      crc_q, crc_d;
   logic [31:0]      sr_q, sr_d;       // delay line, sr_q[31:24] is the oldest byte
   logic [2:0]       fill_q, fill_d;
   logic [LEN_W:0]   cnt_q, cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_runt_q, frame_runt_d;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;

   logic             accept;
   logic             runt_now;
   logic             ok_now;
   logic [LEN_W:0]   len_full;

   assign accept   = in_valid && in_ready_q;
   // fill<4 also covers a frame too short to hold a full trailer
   assign runt_now = (fill_q != 3'd4) || (cnt_q < RUNT_LIM);
   assign ok_now   = (sr_q == crc_q) && !runt_now;
   assign len_full = (cnt_q >= CNT_FOUR) ? (cnt_q - CNT_FOUR) : '0;

   always_comb begin
      state_d      = state_q;
      crc_d        = crc_q;
      sr_d         = sr_q;
      fill_d       = fill_q;
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      frame_ok_d   = frame_ok_q;
      frame_runt_d = frame_runt_q;
      frame_len_d  = frame_len_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               // first byte of a frame: nothing to fold yet
               crc_d   = INIT;
               sr_d    = {sr_q[23:0], in_data};
               fill_d  = 3'd1;
               cnt_d   = CNT_ONE;
               state_d = in_last ? S_CHECK : S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               // a byte leaving a full delay line can no longer be trailer
               if (fill_q == 3'd4) crc_d = crc_byte(crc_q, sr_q[31:24]);
               sr_d   = {sr_q[23:0], in_data};
               fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
               cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
               if (in_last) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            frame_ok_d   = ok_now;
            frame_runt_d = runt_now;
            frame_len_d  = (len_full > LEN_MAX) ? {LEN_W{1'b1}} : len_full[LEN_W-1:0];
         end
         default: state_d = S_IDLE;
      endcase

      in_ready_d = (state_d != S_CHECK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         in_ready_q   <= 1'b1;
         crc_q        <= INIT;
         sr_q         <= '0;
         fill_q       <= '0;
         cnt_q        <= '0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         frame_runt_q <= 1'b0;
         frame_len_q  <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         crc_q        <= crc_d;
         sr_q         <= sr_d;
         fill_q       <= fill_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
         frame_ok_q   <= frame_ok_d;
         frame_runt_q <= frame_runt_d;
         frame_len_q  <= frame_len_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;
   assign frame_runt = frame_runt_q;
   assign frame_len  = frame_len_q;

`ifdef CRC32_CHK_STATS_EN
   logic [15:0] good_q, good_d;
   logic [15:0] bad_q, bad_d;

   // Counters update on the same edge the verdict is registered, so they
   // already reflect the frame while frame_done is high.
   always_comb begin
      good_d = good_q;
      bad_d  = bad_q;
      if (state_q == S_CHECK) begin
         if (ok_now) good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
         else        bad_d  = (bad_q  == 16'hFFFF) ? bad_q  : bad_q  + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         good_q <= '0;
         bad_q  <= '0;
      end else begin
         good_q <= good_d;
         bad_q  <= bad_d;
      end
   end

   assign good_count = good_q;
   assign bad_count  = bad_q;
`else
   assign good_count = 16'd0;
   assign bad_count  = 16'd0;
`endif

endmodule

// File: tb/tb_crc32_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_crc32_frame_checker
//
// Self-checking bench for crc32_frame_checker (built with INIT=0). Directed
// frames from the test plan plus randomized frames, compared against a
// byte-level reference model of the frame rules.
// ---------------------------------------------------------------------------
module tb_crc32_frame_checker;

   localparam logic [31:0] POLY        = 32'h04C11DB7;
   localparam logic [31:0] INIT        = 32'h00000000;
   localparam int          MIN_PAYLOAD = 1;
   localparam int          LEN_W       = 16;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      bit ok;
      bit runt;
      int len;
      int cyc;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_last;
   logic             frame_done;
   logic             frame_ok;
   logic             frame_runt;
   logic [LEN_W-1:0] frame_len;
   logic [15:0]      good_count;
   logic [15:0]      bad_count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   exp_t expq[$];
   int   good_e   = 0;
   int   bad_e    = 0;

   crc32_frame_checker #(
      .POLY       (POLY),
      .INIT       (INIT),
      .MIN_PAYLOAD(MIN_PAYLOAD),
      .LEN_W      (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .frame_done(frame_done),
      .frame_ok  (frame_ok),
      .frame_runt(frame_runt),
      .frame_len (frame_len),
      .good_count(good_count),
      .bad_count (bad_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference CRC: classic MSB-first byte update with the data byte
   // bit-reversed into the top of the register (bit 0 enters first).
   function automatic logic [31:0] ref_crc(input bq_t p);
      logic [31:0] c;
      logic [7:0]  rb;
      c = INIT;
      foreach (p[k]) begin
         for (int b = 0; b < 8; b++) rb[7-b] = p[k][b];
         c = c ^ {rb, 24'h0};
         repeat (8) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
      end
      return c;
   endfunction

   function automatic void model(input bq_t f, output bit ok, output bit runt, output int len);
      int          n;
      bq_t         pay;
      logic [31:0] trl;
      n    = f.size();
      runt = (n < MIN_PAYLOAD + 4);
      len  = (n >= 4) ? n - 4 : 0;
      ok   = 1'b0;
      if (!runt) begin
         for (int k = 0; k < n - 4; k++) pay.push_back(f[k]);
         trl = {f[n-4], f[n-3], f[n-2], f[n-1]};
         ok  = (trl == ref_crc(pay));
      end
   endfunction

   // Drive one whole frame; expectation is queued at the last accept.
   task automatic send_frame(input bq_t f, input bit gaps,
                             input bit e_ok, input bit e_runt, input int e_len);
      exp_t e;
      int   w;
      for (int i = 0; i < f.size(); i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'($urandom);
               in_last  = 1'($urandom);
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = f[i];
         in_last  = (i == f.size() - 1);
         w = 0;
         while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      e.ok   = e_ok;
      e.runt = e_runt;
      e.len  = e_len;
      e.cyc  = cyc;
      expq.push_back(e);
      chk("ready_in_check", {31'd0, in_ready}, 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      int   ng, nb;
      if (rst) begin
         good_e <= 0;
         bad_e  <= 0;
      end else if (frame_done) begin
         if (expq.size() == 0) begin
            chk("spurious_done", {31'd0, frame_done}, 32'd0);
         end else begin
            e = expq.pop_front();
            chk("frame_ok",   {31'd0, frame_ok},   {31'd0, e.ok});
            chk("frame_runt", {31'd0, frame_runt}, {31'd0, e.runt});
            chk("frame_len",  {16'd0, frame_len},  32'(e.len));
            chk("latency",    32'(cyc - e.cyc),    32'd1);
            ng = e.ok ? good_e + 1 : good_e;
            nb = e.ok ? bad_e : bad_e + 1;
            if (ng > 65535) ng = 65535;
            if (nb > 65535) nb = 65535;
            good_e <= ng;
            bad_e  <= nb;
`ifdef CRC32_CHK_STATS_EN
            chk("good_count", {16'd0, good_count}, 32'(ng));
            chk("bad_count",  {16'd0, bad_count},  32'(nb));
`else
            chk("good_count", {16'd0, good_count}, 32'd0);
            chk("bad_count",  {16'd0, bad_count},  32'd0);
`endif
         end
      end
   end

   initial begin
      bq_t f;
      bit  m_ok, m_runt;
      int  m_len, n;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready",      {31'd0, in_ready},   32'd1);
      chk("rst_done",       {31'd0, frame_done}, 32'd0);
      chk("rst_ok",         {31'd0, frame_ok},   32'd0);
      chk("rst_runt",       {31'd0, frame_runt}, 32'd0);
      chk("rst_len",        {16'd0, frame_len},  32'd0);
      chk("rst_good_count", {16'd0, good_count}, 32'd0);
      chk("rst_bad_count",  {16'd0, bad_count},  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Known-good single-byte frame
      f = '{8'h01, 8'h69, 8'h0C, 8'hE0, 8'hEE};
      send_frame(f, 1'b0, 1'b1, 1'b0, 1);
      repeat (4) @(posedge clk);
      #1;
      chk("ok_hold",   {31'd0, frame_ok},   32'd1);
      chk("done_low",  {31'd0, frame_done}, 32'd0);

      // Corrupted trailer
      f = '{8'h01, 8'h69, 8'h0C, 8'hE0, 8'hEF};
      send_frame(f, 1'b0, 1'b0, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;

      // Runt frame; in_ready returns high right after CHECK
      f = '{8'hAA, 8'hBB, 8'hCC};
      send_frame(f, 1'b0, 1'b0, 1'b1, 0);
      @(posedge clk); #1;
      chk("ready_after_check", {31'd0, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #1;

      // Back-to-back frames
      f = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      send_frame(f, 1'b0, 1'b1, 1'b0, 1);
      send_frame(f, 1'b0, 1'b1, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;

      // Stalled valid during payload
      f = '{8'h01, 8'h69, 8'h0C, 8'hE0, 8'hEE};
      send_frame(f, 1'b1, 1'b1, 1'b0, 1);
      repeat (3) @(posedge clk);
      #1;

      // Reset mid-frame, then a valid frame; rst wins over the pending accept
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         in_last  = 1'b0;
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      f = '{8'h12, 8'h34};
      begin
         logic [31:0] c;
         c = ref_crc(f);
         f.push_back(c[31:24]);
         f.push_back(c[23:16]);
         f.push_back(c[15:8]);
         f.push_back(c[7:0]);
      end
      send_frame(f, 1'b0, 1'b1, 1'b0, 2);
      repeat (3) @(posedge clk);
      #1;

      // Randomized frames
      for (int t = 0; t < 30; t++) begin
         f = {};
         n = $urandom_range(1, 12);
         if (n >= 5 && ($urandom_range(0, 3) != 0)) begin
            logic [31:0] c;
            for (int k = 0; k < n - 4; k++) f.push_back(8'($urandom));
            c = ref_crc(f);
            f.push_back(c[31:24]);
            f.push_back(c[23:16]);
            f.push_back(c[15:8]);
            f.push_back(c[7:0]);
            if ($urandom_range(0, 4) == 0) f[$urandom_range(0, n - 1)] ^= 8'h10;
         end else begin
            for (int k = 0; k < n; k++) f.push_back(8'($urandom));
         end
         model(f, m_ok, m_runt, m_len);
         send_frame(f, 1'($urandom), m_ok, m_runt, m_len);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      #1;
      chk("pending_verdicts", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
